// File: rtl/mux_sched_pkg.sv
// Shared types and constants for the three-requester burst scheduler.
package mux_sched_pkg;

  localparam int NUM_REQ = 3;
  localparam int BLEN_W  = 2;

  typedef logic [1:0] src_t;
  localparam src_t SRC_NONE = 2'd0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic src_t next_src(input src_t k);
    return (k == 2'd3) ? 2'd1 : k + 2'd1;
  endfunction

  function automatic logic req_of(input logic [NUM_REQ-1:0] r, input src_t k);
    case (k)
      2'd1:    return r[0];
      2'd2:    return r[1];
      2'd3:    return r[2];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mux_sched_if.sv
// Requester/grant/output bundle for mux_sched; the scheduler is the slave side.
interface mux_sched_if #(parameter int DATA_W = 4);
  logic              req1, req2, req3;
  logic [DATA_W-1:0] ip1, ip2, ip3;
  logic [1:0]        burst_len;
  logic              gnt1, gnt2, gnt3;
  logic              sel1, sel2, sel3;
  logic [DATA_W-1:0] mux_op;
  logic              op_valid;
  logic [1:0]        op_src;

  modport master (
    output req1, req2, req3, ip1, ip2, ip3, burst_len,
    input  gnt1, gnt2, gnt3, sel1, sel2, sel3, mux_op, op_valid, op_src
  );

  modport slave (
    input  req1, req2, req3, ip1, ip2, ip3, burst_len,
    output gnt1, gnt2, gnt3, sel1, sel2, sel3, mux_op, op_valid, op_src
  );
endinterface

// File: rtl/mux_rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping 3 -> 1.
module mux_rr_pick
  import mux_sched_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  src_t               ptr,
  output src_t               win
);

  src_t c0, c1, c2;

  always_comb begin
    c0  = ptr;
    c1  = next_src(c0);
    c2  = next_src(c1);
    win = SRC_NONE;
    // lowest priority first so the highest-priority hit overwrites
    if (req_of(req, c2)) win = c2;
    if (req_of(req, c1)) win = c1;
    if (req_of(req, c0)) win = c0;
  end

endmodule

// File: rtl/mux_sched.sv
// Round-robin burst scheduler muxing three requesters onto one registered output.
//   state | meaning
//   IDLE  | no owner, arbitrate on any req
//   BUSY  | owner holds the channel until burst count reached or its req drops
module mux_sched
  import mux_sched_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  mux_sched_if.slave  bus
);

  state_t              state, state_nx;
  src_t                owner, owner_nx, ptr, ptr_nx, pick_ptr, win;
  logic [BLEN_W-1:0]   blen, blen_nx, cnt, cnt_nx;
  logic [NUM_REQ-1:0]  reqs;
  logic [DATA_W-1:0]   ip_sel;
  logic                own_req, accept, burst_end;

  assign reqs      = {bus.req3, bus.req2, bus.req1};
  assign own_req   = req_of(reqs, owner);
  assign accept    = (state == BUSY) && own_req;
  assign burst_end = (state == BUSY) && (!own_req || (cnt == blen));
  // at burst end the search starts after the owner, so the owner comes last
  assign pick_ptr  = (state == BUSY) ? next_src(owner) : ptr;

  mux_rr_pick u_pick (
    .req (reqs),
    .ptr (pick_ptr),
    .win (win)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      owner <= SRC_NONE;
      ptr   <= 2'd1;
      blen  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      ptr   <= ptr_nx;
      blen  <= blen_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    ptr_nx   = ptr;
    blen_nx  = blen;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (win != SRC_NONE) begin
          state_nx = BUSY;
          owner_nx = win;
          blen_nx  = bus.burst_len;
          cnt_nx   = '0;
        end
      end
      BUSY: begin
        if (accept) cnt_nx = cnt + 2'd1;
        if (burst_end) begin
          ptr_nx = next_src(owner);
          cnt_nx = '0;
          if (win != SRC_NONE) begin
            owner_nx = win;
            blen_nx  = bus.burst_len;
          end else begin
            state_nx = IDLE;
            owner_nx = SRC_NONE;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        owner_nx = SRC_NONE;
      end
    endcase
  end

  always_comb begin
    case (owner)
      2'd1:    ip_sel = bus.ip1;
      2'd2:    ip_sel = bus.ip2;
      2'd3:    ip_sel = bus.ip3;
      default: ip_sel = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.mux_op   <= '0;
      bus.op_valid <= 1'b0;
      bus.op_src   <= SRC_NONE;
    end else if (accept) begin
      bus.mux_op   <= ip_sel;
      bus.op_valid <= 1'b1;
      bus.op_src   <= owner;
    end else begin
      bus.op_valid <= 1'b0;
    end
  end

  assign bus.gnt1 = (state == BUSY) && (owner == 2'd1);
  assign bus.gnt2 = (state == BUSY) && (owner == 2'd2);
  assign bus.gnt3 = (state == BUSY) && (owner == 2'd3);
  assign bus.sel1 = bus.gnt1;
  assign bus.sel2 = bus.gnt2;
  assign bus.sel3 = bus.gnt3;

endmodule

// File: tb/tb_mux_sched.sv
// Directed plus random bench for mux_sched against a cycle-level scheduling model.
module tb_mux_sched;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  mux_sched_if #(.DATA_W(4)) bus ();

  mux_sched #(.DATA_W(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_total = 0;
  int n_pass  = 0;

  // reference model: who owns the channel, beats done, and what the output should show
  int         m_owner, m_ptr, m_beats, m_blen;
  logic [3:0] m_op;
  logic       m_valid;
  logic [1:0] m_src;
  logic [3:0] ip_past [1:3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int pick(input logic [3:1] r, input int start);
    for (int i = 0; i < 3; i++) begin
      int k;
      k = (start - 1 + i) % 3 + 1;
      if (r[k]) return k;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_owner = 0; m_ptr = 1; m_beats = 0; m_blen = 0;
    m_op = '0; m_valid = 1'b0; m_src = '0;
  endtask

  task automatic model_edge();
    logic [3:1] r;
    logic [3:0] ipv [1:3];
    int  bl, w;
    bit  acc, ended;
    r = {bus.req3, bus.req2, bus.req1};
    ipv[1] = bus.ip1; ipv[2] = bus.ip2; ipv[3] = bus.ip3;
    bl = int'(bus.burst_len);
    acc = 0; ended = 0;
    if (m_owner == 0) begin
      w = pick(r, m_ptr);
      if (w != 0) begin m_owner = w; m_blen = bl; m_beats = 0; end
    end else begin
      if (r[m_owner]) begin
        acc = 1;
        m_op = ipv[m_owner];
        m_src = 2'(m_owner);
        m_beats++;
        if (m_beats == m_blen + 1) ended = 1;
      end else ended = 1;
      if (ended) begin
        m_ptr = m_owner % 3 + 1;
        w = pick(r, m_ptr);
        m_owner = w;
        if (w != 0) begin m_blen = bl; m_beats = 0; end
      end
    end
    m_valid = acc;
    for (int k = 1; k <= 3; k++) ip_past[k] = ipv[k];
  endtask

  task automatic check_all();
    logic [2:0] g, s, eg;
    g  = {bus.gnt3, bus.gnt2, bus.gnt1};
    s  = {bus.sel3, bus.sel2, bus.sel1};
    eg = (m_owner == 0) ? 3'b000 : 3'(1 << (m_owner - 1));
    chk("gnt", 32'(g), 32'(eg));
    chk("sel_eq_gnt", 32'(s), 32'(g));
    chk("gnt_onehot0", 32'($onehot0(g)), 32'd1);
    chk("op_valid", 32'(bus.op_valid), 32'(m_valid));
    chk("mux_op", 32'(bus.mux_op), 32'(m_op));
    chk("op_src", 32'(bus.op_src), 32'(m_src));
    if (bus.op_valid === 1'b1 && bus.op_src != 2'd0)
      chk("op_past_ip", 32'(bus.mux_op), 32'(ip_past[bus.op_src]));
  endtask

  task automatic cyc();
    @(posedge clock);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_gnt"}, 32'({bus.gnt3, bus.gnt2, bus.gnt1}), 32'd0);
    chk({tag, "_sel"}, 32'({bus.sel3, bus.sel2, bus.sel1}), 32'd0);
    chk({tag, "_op"}, 32'(bus.mux_op), 32'd0);
    chk({tag, "_valid"}, 32'(bus.op_valid), 32'd0);
    chk({tag, "_src"}, 32'(bus.op_src), 32'd0);
  endtask

  task automatic set_req(input logic r1, input logic r2, input logic r3);
    bus.req1 = r1; bus.req2 = r2; bus.req3 = r3;
  endtask

  initial begin
    set_req(0, 0, 0);
    bus.ip1 = 4'h0; bus.ip2 = 4'h0; bus.ip3 = 4'h0; bus.burst_len = 2'd0;
    model_reset();
    for (int k = 1; k <= 3; k++) ip_past[k] = '0;
    #12;
    check_zero("reset");
    #1 reset_n = 1'b1;
    cyc(); cyc();

    // single request from reset, held until its beat is taken
    set_req(0, 1, 0); bus.ip2 = 4'hA; bus.burst_len = 2'd0;
    cyc(); chk("s1_gnt2", 32'(bus.gnt2), 32'd1);
    cyc(); chk("s1_mux_op", 32'(bus.mux_op), 32'hA);
           chk("s1_src", 32'(bus.op_src), 32'd2);
    set_req(0, 0, 0);
    cyc(); cyc();
    chk("s1_idle", 32'({bus.gnt3, bus.gnt2, bus.gnt1}), 32'd0);
    // pointer now past requester 2: 3 beats 1
    set_req(1, 0, 1); bus.ip1 = 4'h5; bus.ip3 = 4'h6;
    cyc(); chk("s1_ptr3", 32'(bus.gnt3), 32'd1);
    set_req(0, 0, 0);
    cyc(); cyc(); cyc();

    // full contention, single-beat grants
    set_req(1, 1, 1); bus.burst_len = 2'd0;
    for (int i = 0; i < 9; i++) begin
      bus.ip1 = 4'(i); bus.ip2 = 4'(i + 4); bus.ip3 = 4'(i + 8);
      cyc();
    end
    set_req(0, 0, 0);
    cyc(); cyc(); cyc();

    // four-beat burst on 3, burst_len changed and req1 raised mid-burst
    set_req(0, 0, 1); bus.burst_len = 2'd3;
    cyc(); chk("b_gnt3", 32'(bus.gnt3), 32'd1);
    bus.burst_len = 2'd0;
    for (int i = 0; i < 4; i++) begin
      bus.ip3 = 4'(i + 1);
      if (i == 1) begin bus.req1 = 1'b1; bus.ip1 = 4'hC; end
      cyc();
      chk("b_beat", 32'(bus.mux_op), 32'(i + 1));
      chk("b_valid", 32'(bus.op_valid), 32'd1);
    end
    chk("b_next_gnt1", 32'(bus.gnt1), 32'd1);
    set_req(1, 0, 0);
    cyc();
    set_req(0, 0, 0);
    cyc(); cyc(); cyc();

    // early drop by owner 1 after two beats while 2 waits
    set_req(1, 0, 0); bus.burst_len = 2'd3; bus.ip1 = 4'h7;
    cyc(); chk("d_gnt1", 32'(bus.gnt1), 32'd1);
    bus.req2 = 1'b1; bus.ip2 = 4'h9;
    cyc(); chk("d_no_steal", 32'(bus.gnt2), 32'd0);
    bus.ip1 = 4'h8;
    cyc();
    set_req(0, 1, 0);
    cyc(); chk("d_valid_low", 32'(bus.op_valid), 32'd0);
           chk("d_gnt2", 32'(bus.gnt2), 32'd1);
    cyc();

    // asynchronous reset in the middle of a burst on 2
    set_req(0, 1, 0); bus.burst_len = 2'd3;
    cyc(); cyc();
    chk("r_gnt2_before", 32'(bus.gnt2), 32'd1);
    #2 reset_n = 1'b0;
    #1 check_zero("midrst");
    model_reset();
    set_req(1, 0, 1); bus.burst_len = 2'd0; bus.ip1 = 4'h3; bus.ip3 = 4'h4;
    #1 reset_n = 1'b1;
    cyc(); chk("r_gnt1_first", 32'(bus.gnt1), 32'd1);
    cyc(); cyc(); cyc();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [2:0] r;
      r = 3'($urandom_range(0, 7));
      set_req(r[0], r[1], r[2]);
      bus.ip1 = 4'($urandom); bus.ip2 = 4'($urandom); bus.ip3 = 4'($urandom);
      bus.burst_len = 2'($urandom);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
